// File: rtl/ram_arbiter_pkg.sv
// Shared types and widths for the video-read / terminal-write RAM arbiter.
package ram_arbiter_pkg;

    localparam int RAM_ADDR_W  = 23;
    localparam int RAM_DATA_W  = 32;
    localparam int RAM_MASK_W  = 4;
    localparam int RAM_BURST_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ram_arbiter_watchdog.sv
// Per-grant watchdog: counts enabled cycles without a progress pulse and flags
// expiry on the TIMEOUT-th consecutive idle cycle so the grant can be dropped.
module arb_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    input  logic progress,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || progress) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = count_en && !progress && !clear && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester RAM arbiter: video burst reads vs. terminal writes with write
// anti-starvation and a per-grant watchdog. Grant counters exist only when
// RAM_ARBITER_STATS_EN is defined.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 64,
    parameter int TIMEOUT      = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        v_rd_request,
    input  logic [22:0] v_rd_address,
    input  logic [8:0]  v_rd_burst_length,
    output logic        v_rd_available,
    output logic [31:0] v_rd_data,
    input  logic        t_wr_request,
    input  logic [22:0] t_wr_address,
    input  logic [31:0] t_wr_data,
    input  logic [3:0]  t_wr_mask,
    input  logic [8:0]  t_wr_burst_length,
    output logic        t_wr_done,
    output logic        m_rd_request,
    output logic [22:0] m_rd_address,
    output logic [8:0]  m_rd_burst_length,
    input  logic        m_rd_available,
    input  logic [31:0] m_rd_data,
    output logic        m_wr_request,
    output logic [22:0] m_wr_address,
    output logic [31:0] m_wr_data,
    output logic [3:0]  m_wr_mask,
    output logic [8:0]  m_wr_burst_length,
    input  logic        m_wr_done,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] stat_rd_grants,
    output logic [15:0] stat_wr_grants
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e             state, state_nxt;
    logic [RAM_ADDR_W-1:0]  lat_addr, addr_nxt;
    logic [RAM_BURST_W-1:0] lat_len, len_nxt, rd_cnt;
    logic [RAM_MASK_W-1:0]  lat_mask, mask_nxt;
    logic [STARVE_W-1:0]    starve_cnt;
    logic                   rd_req_q, wr_req_q, timeout_err_q;
    logic                   grant_rd, grant_wr, rd_pulse, wr_pulse;
    logic                   finish, abort, wd_expired;

    assign grant_wr = (state == IDLE) && t_wr_request &&
                      (!v_rd_request || (starve_cnt >= STARVE_W'(STARVE_LIMIT)));
    assign grant_rd = (state == IDLE) && v_rd_request && !grant_wr;

    // RAM pulses only count while the matching request is live; strays vanish here
    assign rd_pulse = rd_req_q && m_rd_available;
    assign wr_pulse = wr_req_q && m_wr_done;

    assign finish = ((state == READ) &&
                     ((lat_len == '0) || ((rd_cnt + RAM_BURST_W'(rd_pulse)) == lat_len))) ||
                    ((state == WRITE) && ((lat_len == '0) || wr_pulse));
    assign abort  = wd_expired && !finish;

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .count_en (state != IDLE),
        .progress (rd_pulse || wr_pulse),
        .clear    (state == IDLE),
        .expired  (wd_expired)
    );

    always_comb begin
        state_nxt = state;
        addr_nxt  = lat_addr;
        len_nxt   = lat_len;
        mask_nxt  = lat_mask;
        case (state)
            IDLE: begin
                if (grant_wr) begin
                    state_nxt = WRITE;
                    addr_nxt  = t_wr_address;
                    len_nxt   = t_wr_burst_length;
                    mask_nxt  = t_wr_mask;
                end else if (grant_rd) begin
                    state_nxt = READ;
                    addr_nxt  = v_rd_address;
                    len_nxt   = v_rd_burst_length;
                    mask_nxt  = '0;
                end
            end
            READ, WRITE: begin
                if (finish || abort) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rd_req_q      <= 1'b0;
            wr_req_q      <= 1'b0;
            rd_cnt        <= '0;
            starve_cnt    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            // zero-length grants occupy one cycle but never reach the RAM
            rd_req_q <= (state_nxt == READ)  && (len_nxt != '0);
            wr_req_q <= (state_nxt == WRITE) && (len_nxt != '0);
            if (state == IDLE) rd_cnt <= '0;
            else if (rd_pulse) rd_cnt <= rd_cnt + 1'b1;
            if (grant_wr) begin
                starve_cnt <= '0;
            end else if (t_wr_request && (state != WRITE) &&
                         (starve_cnt < STARVE_W'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            if (abort) timeout_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        lat_addr <= addr_nxt;
        lat_len  <= len_nxt;
        lat_mask <= mask_nxt;
    end

`ifdef RAM_ARBITER_STATS_EN
    logic [15:0] rd_grants, wr_grants;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_grants <= '0;
            wr_grants <= '0;
        end else begin
            if (grant_rd && (rd_grants != 16'hFFFF)) rd_grants <= rd_grants + 1'b1;
            if (grant_wr && (wr_grants != 16'hFFFF)) wr_grants <= wr_grants + 1'b1;
        end
    end

    assign stat_rd_grants = rd_grants;
    assign stat_wr_grants = wr_grants;
`else
    assign stat_rd_grants = '0;
    assign stat_wr_grants = '0;
`endif

    assign busy              = (state != IDLE);
    assign timeout_err       = timeout_err_q;
    assign m_rd_request      = rd_req_q;
    assign m_rd_address      = rd_req_q ? lat_addr : '0;
    assign m_rd_burst_length = rd_req_q ? lat_len  : '0;
    assign m_wr_request      = wr_req_q;
    assign m_wr_address      = wr_req_q ? lat_addr : '0;
    assign m_wr_mask         = wr_req_q ? lat_mask : '0;
    assign m_wr_burst_length = wr_req_q ? lat_len  : '0;
    assign m_wr_data         = wr_req_q ? t_wr_data : '0;
    assign v_rd_available    = rd_pulse;
    assign v_rd_data         = rd_pulse ? m_rd_data : '0;
    assign t_wr_done         = wr_pulse;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic, all
// checked each cycle against a transaction-level model of the arbiter.
module tb_ram_arbiter;

    localparam int STARVE = 64;
    localparam int TMO    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v_rd_request = 1'b0;
    logic [22:0] v_rd_address = '0;
    logic [8:0]  v_rd_burst_length = '0;
    logic        v_rd_available;
    logic [31:0] v_rd_data;
    logic        t_wr_request = 1'b0;
    logic [22:0] t_wr_address = '0;
    logic [31:0] t_wr_data = '0;
    logic [3:0]  t_wr_mask = '0;
    logic [8:0]  t_wr_burst_length = '0;
    logic        t_wr_done;
    logic        m_rd_request;
    logic [22:0] m_rd_address;
    logic [8:0]  m_rd_burst_length;
    logic        m_rd_available = 1'b0;
    logic [31:0] m_rd_data = '0;
    logic        m_wr_request;
    logic [22:0] m_wr_address;
    logic [31:0] m_wr_data;
    logic [3:0]  m_wr_mask;
    logic [8:0]  m_wr_burst_length;
    logic        m_wr_done = 1'b0;
    logic        busy;
    logic        timeout_err;
    logic [15:0] stat_rd_grants;
    logic [15:0] stat_wr_grants;

    ram_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .v_rd_request(v_rd_request), .v_rd_address(v_rd_address),
        .v_rd_burst_length(v_rd_burst_length), .v_rd_available(v_rd_available),
        .v_rd_data(v_rd_data),
        .t_wr_request(t_wr_request), .t_wr_address(t_wr_address), .t_wr_data(t_wr_data),
        .t_wr_mask(t_wr_mask), .t_wr_burst_length(t_wr_burst_length), .t_wr_done(t_wr_done),
        .m_rd_request(m_rd_request), .m_rd_address(m_rd_address),
        .m_rd_burst_length(m_rd_burst_length), .m_rd_available(m_rd_available),
        .m_rd_data(m_rd_data),
        .m_wr_request(m_wr_request), .m_wr_address(m_wr_address), .m_wr_data(m_wr_data),
        .m_wr_mask(m_wr_mask), .m_wr_burst_length(m_wr_burst_length), .m_wr_done(m_wr_done),
        .busy(busy), .timeout_err(timeout_err),
        .stat_rd_grants(stat_rd_grants), .stat_wr_grants(stat_wr_grants)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // RAM behaviour knobs
    int rd_pct = 0;
    int wr_pct = 0;
    bit stray = 1'b0;
    bit force_rd = 1'b0;

    always @(negedge clk) begin
        m_rd_data      = $urandom;
        m_rd_available = force_rd ||
                         (m_rd_request && ($urandom_range(0, 99) < rd_pct)) ||
                         (stray && !m_rd_request && ($urandom_range(0, 7) == 0));
        m_wr_done      = (m_wr_request && ($urandom_range(0, 99) < wr_pct)) ||
                         (stray && !m_wr_request && ($urandom_range(0, 7) == 0));
    end

    // Model: which grant is open (0 none, 1 read, 2 write), what was latched,
    // words seen, idle cycles, write-wait count, sticky error, grant totals.
    int          mk = 0, mgot = 0, mwait = 0, mstarve = 0;
    logic [22:0] maddr = '0;
    logic [8:0]  mlen = '0;
    logic [3:0]  mmask = '0;
    logic        merr = 1'b0;
    logic [15:0] mst_rd = '0, mst_wr = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_cycle();
        logic         lrd, lwr, pav, pdn, ebusy;
        logic [15:0]  esr, esw;
        logic [169:0] e, a;
        if (!rst_n) begin
            mk = 0; mgot = 0; mwait = 0; mstarve = 0; mlen = '0;
            merr = 1'b0; mst_rd = '0; mst_wr = '0;
        end
        lrd   = (mk == 1) && (mlen != 0);
        lwr   = (mk == 2) && (mlen != 0);
        pav   = lrd && m_rd_available;
        pdn   = lwr && m_wr_done;
        ebusy = (mk != 0);
`ifdef RAM_ARBITER_STATS_EN
        esr = mst_rd; esw = mst_wr;
`else
        esr = 16'd0; esw = 16'd0;
`endif
        e = {ebusy, lrd, lrd ? maddr : 23'd0, lrd ? mlen : 9'd0,
             lwr, lwr ? maddr : 23'd0, lwr ? t_wr_data : 32'd0, lwr ? mmask : 4'd0,
             lwr ? mlen : 9'd0, pav, pav ? m_rd_data : 32'd0, pdn, merr, esr, esw};
        a = {busy, m_rd_request, m_rd_address, m_rd_burst_length,
             m_wr_request, m_wr_address, m_wr_data, m_wr_mask, m_wr_burst_length,
             v_rd_available, v_rd_data, t_wr_done, timeout_err, stat_rd_grants, stat_wr_grants};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL cycle_model t=%0t: got %h expected %h", $time, a, e);
        end
        if (rst_n) begin
            case (mk)
                0: begin
                    if (t_wr_request && (mstarve >= STARVE || !v_rd_request)) begin
                        mk = 2; maddr = t_wr_address; mlen = t_wr_burst_length;
                        mmask = t_wr_mask; mstarve = 0;
                        if (mst_wr != 16'hFFFF) mst_wr++;
                    end else begin
                        if (t_wr_request && mstarve < STARVE) mstarve++;
                        if (v_rd_request) begin
                            mk = 1; maddr = v_rd_address; mlen = v_rd_burst_length; mmask = '0;
                            if (mst_rd != 16'hFFFF) mst_rd++;
                        end
                    end
                    mgot = 0; mwait = 0;
                end
                1: begin
                    if (t_wr_request && mstarve < STARVE) mstarve++;
                    if (mlen == 0) mk = 0;
                    else if (m_rd_available) begin
                        mgot++; mwait = 0;
                        if (mgot == int'(mlen)) mk = 0;
                    end else begin
                        mwait++;
                        if (mwait == TMO) begin mk = 0; merr = 1'b1; end
                    end
                end
                default: begin
                    if (mlen == 0 || m_wr_done) mk = 0;
                    else begin
                        mwait++;
                        if (mwait == TMO) begin mk = 0; merr = 1'b1; end
                    end
                end
            endcase
        end
    endtask

    always @(negedge clk) begin
        #2;
        model_cycle();
    end

    // Runs one grant to completion, sampling at negedge+1; returns in the IDLE cycle.
    task automatic finish_grant(output int cyc, output int np, output int nd,
                                output logic first_rd, output logic first_wr,
                                output logic rd_seen);
        bit seen;
        seen = 1'b0; cyc = 0; np = 0; nd = 0;
        first_rd = 1'b0; first_wr = 1'b0; rd_seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (busy) begin
                if (!seen) begin first_rd = m_rd_request; first_wr = m_wr_request; end
                seen = 1'b1;
                cyc++;
            end
            if (v_rd_available) np++;
            if (t_wr_done) nd++;
            if (m_rd_request) rd_seen = 1'b1;
            if (seen && !busy) return;
        end
        checks++; errors++;
        $display("FAIL grant_bound: got no return to IDLE within 400 cycles, required IDLE");
    endtask

    initial begin
        int cyc, np, nd, n;
        logic fr, fw, rs;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {busy, m_rd_request, m_wr_request, v_rd_available, t_wr_done,
                              timeout_err, stat_rd_grants, stat_wr_grants}, 0);
        rst_n = 1'b1;

        // Read burst of 8 at 0x000100
        v_rd_address = 23'h000100; v_rd_burst_length = 9'd8; rd_pct = 100; v_rd_request = 1'b1;
        finish_grant(cyc, np, nd, fr, fw, rs);
        v_rd_request = 1'b0;
        chk("s1_pulses", np, 8);
        chk("s1_first_is_read", fr, 1);
        chk("s1_busy_cycles", cyc, 8);
        @(negedge clk); #1;
        chk("s1_idle_busy", busy, 0);
`ifdef RAM_ARBITER_STATS_EN
        chk("s1_stat_rd", stat_rd_grants, 1);
        chk("s1_stat_wr", stat_wr_grants, 0);
`else
        chk("s1_stat_rd", stat_rd_grants, 0);
        chk("s1_stat_wr", stat_wr_grants, 0);
`endif

        // Simultaneous requests, starve count 0: read first, then write
        v_rd_address = 23'h000200; v_rd_burst_length = 9'd3;
        t_wr_address = 23'h000300; t_wr_burst_length = 9'd2; t_wr_mask = 4'hA;
        t_wr_data = 32'hCAFE_0001; wr_pct = 100;
        v_rd_request = 1'b1; t_wr_request = 1'b1;
        finish_grant(cyc, np, nd, fr, fw, rs);
        v_rd_request = 1'b0;
        chk("s2_read_first", fr, 1);
        chk("s2_no_write_first", fw, 0);
        chk("s2_read_pulses", np, 3);
        finish_grant(cyc, np, nd, fr, fw, rs);
        t_wr_request = 1'b0;
        chk("s2_write_next", fw, 1);
        chk("s2_write_done", nd, 1);

        // Zero-length read
        v_rd_burst_length = 9'd0; v_rd_request = 1'b1;
        finish_grant(cyc, np, nd, fr, fw, rs);
        v_rd_request = 1'b0;
        chk("s4_busy_cycles", cyc, 1);
        chk("s4_no_ram_request", rs, 0);
        chk("s4_no_pulses", np, 0);

        // Write with a silent RAM: aborted after TMO cycles
        t_wr_burst_length = 9'd5; wr_pct = 0; t_wr_request = 1'b1;
        finish_grant(cyc, np, nd, fr, fw, rs);
        t_wr_request = 1'b0;
        chk("s5_granted_write", fw, 1);
        chk("s5_abort_cycles", cyc, TMO);
        chk("s5_no_done", nd, 0);
        chk("s5_timeout_err", timeout_err, 1);

        // Continuous 4-word reads with a write waiting
        v_rd_address = 23'h000400; v_rd_burst_length = 9'd4; rd_pct = 100;
        t_wr_address = 23'h000500; t_wr_burst_length = 9'd2; wr_pct = 100;
        v_rd_request = 1'b1; t_wr_request = 1'b1;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            n++;
            if (m_wr_request) break;
        end
        chk("s3_write_grant_cycle", n, 66);
        chk("s3_starve_cleared", dut.starve_cnt, 0);
        chk("s3_read_dropped", m_rd_request, 0);
        v_rd_request = 1'b0; t_wr_request = 1'b0;
        @(negedge clk); #1;
        chk("s3_idle", busy, 0);
        chk("s3_err_sticky", timeout_err, 1);

        // Reset during the third word of a read burst
        v_rd_address = 23'h000600; v_rd_burst_length = 9'd8; rd_pct = 100; v_rd_request = 1'b1;
        np = 0;
        for (int i = 0; i < 50 && np < 2; i++) begin
            @(negedge clk); #1;
            if (v_rd_available) np++;
        end
        @(negedge clk); #1;
        chk("s6_third_word", v_rd_available, 1);
        rst_n = 1'b0;
        #1;
        chk("s6_reset_outputs", {busy, m_rd_request, v_rd_available, v_rd_data, timeout_err}, 0);
        @(negedge clk); #1;
        rst_n = 1'b1; v_rd_request = 1'b0; force_rd = 1'b1;
        @(negedge clk); #1;
        chk("s6_late_pulse_dropped", v_rd_available, 0);
        chk("s6_idle", busy, 0);
        force_rd = 1'b0;

        // Randomized traffic
        stray = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); #1;
            if (i % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0: rd_pct = 0;
                    1: rd_pct = 30;
                    2: rd_pct = 70;
                    default: rd_pct = 100;
                endcase
                wr_pct = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(20, 100));
            end
            if ($urandom_range(0, 3) == 0) v_rd_request = ~v_rd_request;
            if ($urandom_range(0, 5) == 0) t_wr_request = ~t_wr_request;
            v_rd_address      = 23'($urandom);
            v_rd_burst_length = ($urandom_range(0, 9) == 0) ? 9'd0 : 9'($urandom_range(1, 6));
            t_wr_address      = 23'($urandom);
            t_wr_burst_length = ($urandom_range(0, 9) == 0) ? 9'd0 : 9'($urandom_range(1, 4));
            t_wr_data         = $urandom;
            t_wr_mask         = 4'($urandom);
            rst_n             = ($urandom_range(0, 599) != 0);
        end
        stray = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #3;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 64: write-wait cycles after which a pending write beats a pending read.
REQ-002 SHALL have parameter TIMEOUT, default 4096: cycles without RAM progress before a grant is aborted.
REQ-003 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; every register clocks on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- v_rd_request  in  1  video read request; the requester holds it high until its burst completes.
- v_rd_address  in  23  video read word address.
- v_rd_burst_length  in  9  number of words in the video read burst.
- v_rd_available  out  1  one pulse per delivered read word.
- v_rd_data  out  32  read word; valid while v_rd_available is high.
- t_wr_request  in  1  terminal write request; the requester holds it high until t_wr_done.
- t_wr_address  in  23  terminal write word address.
- t_wr_data  in  32  terminal write data.
- t_wr_mask  in  4  terminal write byte mask.
- t_wr_burst_length  in  9  terminal write burst length.
- t_wr_done  out  1  write-complete pulse.
- m_rd_request, m_rd_address[23], m_rd_burst_length[9]  out  RAM read port.
- m_rd_available[1], m_rd_data[32]  in  RAM read return.
- m_wr_request, m_wr_address[23], m_wr_data[32], m_wr_mask[4], m_wr_burst_length[9]  out  RAM write port.
- m_wr_done  in  1  RAM write-complete pulse.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky flag set when a grant is aborted.
- stat_rd_grants, stat_wr_grants  out  16 each  grant counters.

Function
REQ-004 SHALL implement states IDLE, READ, WRITE.
REQ-005 In IDLE, the arbiter SHALL grant READ when v_rd_request is high, except that it SHALL grant WRITE when t_wr_request is high and starve_cnt is at least STARVE_LIMIT.
REQ-006 In IDLE, the arbiter SHALL grant WRITE when only t_wr_request is high; with no request pending it SHALL stay in IDLE.
REQ-007 A request sampled in IDLE at cycle n SHALL produce a registered m_rd_request or m_wr_request at cycle n+1.
REQ-008 At grant, the arbiter SHALL latch address, burst length and mask; the latched values SHALL stay stable for the whole grant.
REQ-009 m_rd_request and m_wr_request SHALL each be held high for the whole grant; at most one of them SHALL be high in any cycle.
REQ-010 In READ, m_rd_data SHALL pass to v_rd_data and m_rd_available to v_rd_available combinationally.
REQ-011 In READ, a 9-bit counter SHALL count m_rd_available pulses; on reaching the latched length the arbiter SHALL return to IDLE on the next cycle.
REQ-012 A grant with latched burst length 0 SHALL return to IDLE after one cycle, assert no RAM request and produce no pulses.
REQ-013 In WRITE, t_wr_data SHALL pass to m_wr_data combinationally, and m_wr_done to t_wr_done.
REQ-014 In WRITE, m_wr_done SHALL return the arbiter to IDLE on the next cycle.
REQ-015 Outside READ, v_rd_available SHALL be 0; outside WRITE, t_wr_done SHALL be 0; a stray RAM pulse SHALL be dropped.
REQ-016 If the requester drops its request mid-grant, the arbiter SHALL still complete the grant (the RAM cannot abort a burst).
REQ-017 starve_cnt SHALL increment in each cycle t_wr_request is high and the state is not WRITE, saturate at STARVE_LIMIT, and clear on a WRITE grant.
REQ-018 A per-grant watchdog SHALL count cycles without an m_rd_available or m_wr_done pulse.
REQ-019 When the watchdog reaches TIMEOUT, the arbiter SHALL go to IDLE, drop the RAM request and set timeout_err; timeout_err SHALL clear only on reset.

Reset
REQ-020 While rst_n is low, the arbiter SHALL be in IDLE, every counter SHALL be 0, and every output SHALL be 0, including timeout_err and the stat counters.
REQ-021 A reset asserted mid-burst SHALL abandon the burst immediately, and no pulse SHALL be forwarded afterwards.

Configuration
REQ-022 With RAM_ARBITER_STATS_EN defined, stat_rd_grants and stat_wr_grants SHALL increment once per READ or WRITE grant and saturate at 16'hFFFF.
REQ-023 With RAM_ARBITER_STATS_EN undefined, both stat outputs SHALL be constant 0 and their counter registers SHALL be absent.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE/READ/WRITE), RAM_ADDR_W=23, RAM_DATA_W=32, RAM_MASK_W=4 and RAM_BURST_W=9.
REQ-025 The watchdog SHALL be a sub-module arb_watchdog (inputs: count-enable, progress pulse, clear; output: expired); arbitration SHALL stay in the top module.

Verification
REQ-026 The bench SHALL cover:
- Read, burst 8 at address 0x000100, with RAM returning 8 pulses → exactly 8 v_rd_available pulses, then IDLE, busy=0.
- Simultaneous read and write requests with starve_cnt=0 → read granted first; write granted right after the read completes.
- Continuous reads with a write pending 64 cycles → write granted at the next IDLE; starve_cnt returns to 0.
- Read grant with burst length 0 → m_rd_request never asserted; IDLE after 1 cycle.
- Write, RAM never returns m_wr_done, TIMEOUT=16 → abort 16 cycles after the grant; timeout_err=1.
- rst_n low during the 3rd word of a read burst → all outputs 0 at once; a later m_rd_available is not forwarded.
